// File: rtl/pwm_regbank_pkg.sv
// pwm_regbank_pkg: register map constants and byte helpers shared by the PWM register bank
package pwm_regbank_pkg;
    localparam logic [5:0] A_PERIOD_L  = 6'h00;
    localparam logic [5:0] A_PERIOD_H  = 6'h01;
    localparam logic [5:0] A_CTRL      = 6'h02;
    localparam logic [5:0] A_PRESCALE  = 6'h03;
    localparam logic [5:0] A_CNT_RST   = 6'h04;
    localparam logic [5:0] A_CNT_VAL_L = 6'h05;
    localparam logic [5:0] A_CNT_VAL_H = 6'h06;
    localparam logic [5:0] A_STATUS    = 6'h07;
    localparam logic [5:0] A_IRQ_MASK  = 6'h08;
    localparam logic [5:0] A_FORCE_UPD = 6'h09;
    localparam logic [5:0] CH_BASE     = 6'h10;
    localparam int         CH_STRIDE   = 8;
    localparam logic [2:0] O_CMP1_L    = 3'd0;
    localparam logic [2:0] O_CMP2_L    = 3'd2;
    localparam logic [2:0] O_FUNC      = 3'd4;
    localparam int CTRL_EN        = 0;
    localparam int CTRL_UPDN      = 1;
    localparam int CTRL_PWM_EN    = 2;
    localparam int CTRL_SHADOW_EN = 3;
    // Registers are at most 16 bits; narrower ones truncate, so high-byte writes vanish and reads give 0.
    function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
        logic [15:0] r;
        r = v;
        if (hi) r[15:8] = b;
        else r[7:0] = b;
        return r;
    endfunction
    function automatic logic [7:0] get_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction
endpackage

// File: rtl/pwm_ch_regs.sv
// pwm_ch_regs: per-channel double-buffered compare/function registers and W1C status bit
module pwm_ch_regs
    import pwm_regbank_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [2:0]       off,
    input  logic [7:0]       wdata,
    input  logic             commit,
    input  logic             shadow_en,
    input  logic             cmp_evt,
    input  logic             clr,
    output logic [CNT_W-1:0] cmp1,
    output logic [CNT_W-1:0] cmp2,
    output logic [1:0]       func,
    output logic             status,
    output logic [7:0]       rd_data
);
    logic [CNT_W-1:0] cmp1_sh, cmp2_sh, cmp1_sh_nx, cmp2_sh_nx;
    logic [1:0] func_sh, func_sh_nx;

    always_comb begin
        cmp1_sh_nx = (wr && off[2:1] == O_CMP1_L[2:1]) ? CNT_W'(put_byte(16'(cmp1_sh), off[0], wdata)) : cmp1_sh;
        cmp2_sh_nx = (wr && off[2:1] == O_CMP2_L[2:1]) ? CNT_W'(put_byte(16'(cmp2_sh), off[0], wdata)) : cmp2_sh;
        func_sh_nx = (wr && off == O_FUNC) ? wdata[1:0] : func_sh;
        rd_data = (off == O_FUNC) ? {6'd0, func_sh} :
                  (off[2:1] == O_CMP1_L[2:1]) ? get_byte(16'(cmp1_sh), off[0]) :
                  (off[2:1] == O_CMP2_L[2:1]) ? get_byte(16'(cmp2_sh), off[0]) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp1_sh <= '0;
            cmp2_sh <= '0;
            func_sh <= '0;
            cmp1 <= '0;
            cmp2 <= '0;
            func <= '0;
            status <= 1'b0;
        end else begin
            cmp1_sh <= cmp1_sh_nx;
            cmp2_sh <= cmp2_sh_nx;
            func_sh <= func_sh_nx;
            // A commit takes the registered shadow, so a same-edge write waits for the next commit.
            if (!shadow_en) begin
                cmp1 <= cmp1_sh_nx;
                cmp2 <= cmp2_sh_nx;
                func <= func_sh_nx;
            end else if (commit) begin
                cmp1 <= cmp1_sh;
                cmp2 <= cmp2_sh;
                func <= func_sh;
            end
            status <= cmp_evt | (status & ~clr);
        end
    end
endmodule

// File: rtl/pwm_regbank_mc.sv
// pwm_regbank_mc: byte-addressed register bank for a multi-channel PWM timer
module pwm_regbank_mc
    import pwm_regbank_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read,
    input  logic                    write,
    input  logic [5:0]              addr,
    input  logic [7:0]              data_write,
    output logic [7:0]              data_read,
    output logic                    rd_valid,
    input  logic [CNT_W-1:0]        counter_val,
    input  logic                    period_evt,
    input  logic [NUM_CH-1:0]       cmp_evt,
    output logic [CNT_W-1:0]        period,
    output logic                    en,
    output logic                    upnotdown,
    output logic                    pwm_en,
    output logic                    count_reset,
    output logic [7:0]              prescale,
    output logic [CNT_W*NUM_CH-1:0] compare1,
    output logic [CNT_W*NUM_CH-1:0] compare2,
    output logic [2*NUM_CH-1:0]     functions,
    output logic                    irq
);
    logic [3:0] ctrl;
    logic [NUM_CH-1:0] irq_mask, status, status_clr;
    logic [CNT_W-1:0] period_sh, period_sh_nx;
    logic [5:0] ch_rel;
    logic [2:0] ch_idx;
    logic ch_hit, shadow_en, commit;
    logic [7:0] ch_rd [NUM_CH];
    logic [7:0] ch_sel, rd_mux;

    assign en = ctrl[CTRL_EN];
    assign upnotdown = ctrl[CTRL_UPDN];
    assign pwm_en = ctrl[CTRL_PWM_EN];
    assign shadow_en = ctrl[CTRL_SHADOW_EN];
    assign ch_rel = addr - CH_BASE;
    assign ch_hit = addr >= CH_BASE;
    assign ch_idx = 3'(ch_rel / 6'(CH_STRIDE));
    assign commit = period_evt || (write && addr == A_FORCE_UPD && data_write[0]);
    assign status_clr = (write && addr == A_STATUS) ? data_write[NUM_CH-1:0] : '0;
    assign period_sh_nx = (write && (addr == A_PERIOD_L || addr == A_PERIOD_H)) ?
                          CNT_W'(put_byte(16'(period_sh), addr[0], data_write)) : period_sh;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_ch_regs #(.CNT_W(CNT_W)) u_ch (
            .clk(clk),
            .rst_n(rst_n),
            .wr(write && ch_hit && ch_idx == 3'(c)),
            .off(ch_rel[2:0]),
            .wdata(data_write),
            .commit(commit),
            .shadow_en(shadow_en),
            .cmp_evt(cmp_evt[c]),
            .clr(status_clr[c]),
            .cmp1(compare1[c*CNT_W +: CNT_W]),
            .cmp2(compare2[c*CNT_W +: CNT_W]),
            .func(functions[2*c +: 2]),
            .status(status[c]),
            .rd_data(ch_rd[c])
        );
    end

    // Channels past NUM_CH and the 0x30+ range never match, so they read 0.
    always_comb begin
        ch_sel = 8'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_hit && ch_idx == 3'(i)) ch_sel = ch_rd[i];
    end

    always_comb begin
        case (addr)
            A_PERIOD_L:  rd_mux = get_byte(16'(period_sh), 1'b0);
            A_PERIOD_H:  rd_mux = get_byte(16'(period_sh), 1'b1);
            A_CTRL:      rd_mux = {4'd0, ctrl};
            A_PRESCALE:  rd_mux = prescale;
            A_CNT_VAL_L: rd_mux = get_byte(16'(counter_val), 1'b0);
            A_CNT_VAL_H: rd_mux = get_byte(16'(counter_val), 1'b1);
            A_STATUS:    rd_mux = 8'(status);
            A_IRQ_MASK:  rd_mux = 8'(irq_mask);
            default:     rd_mux = ch_sel;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh <= '0;
            period <= '0;
            ctrl <= '0;
            prescale <= '0;
            irq_mask <= '0;
            count_reset <= 1'b0;
            irq <= 1'b0;
            data_read <= '0;
            rd_valid <= 1'b0;
        end else begin
            period_sh <= period_sh_nx;
            if (!shadow_en) period <= period_sh_nx;
            else if (commit) period <= period_sh;
            if (write && addr == A_CTRL) ctrl <= data_write[3:0];
            if (write && addr == A_PRESCALE) prescale <= data_write;
            if (write && addr == A_IRQ_MASK) irq_mask <= data_write[NUM_CH-1:0];
            count_reset <= write && addr == A_CNT_RST && data_write[0];
            irq <= |(status & irq_mask);
            data_read <= read ? rd_mux : 8'd0;
            rd_valid <= read;
        end
    end
endmodule

// File: tb/tb_pwm_regbank_mc.sv
// tb_pwm_regbank_mc: directed checks of a 16-bit and an 8-bit bank driven from one shared bus
module tb_pwm_regbank_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic read = 1'b0, write = 1'b0, period_evt = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] data_write = '0;
    logic [15:0] counter_val = '0;
    logic [1:0] cmp_evt = '0;

    logic [7:0] data_read, prescale, data_read_8, prescale_8;
    logic rd_valid, en, upnotdown, pwm_en, count_reset, irq;
    logic rd_valid_8, en_8, upnotdown_8, pwm_en_8, count_reset_8, irq_8;
    logic [15:0] period;
    logic [7:0] period_8;
    logic [31:0] compare1, compare2;
    logic [15:0] compare1_8, compare2_8;
    logic [3:0] functions, functions_8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_regbank_mc #(.NUM_CH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read), .rd_valid(rd_valid),
        .counter_val(counter_val), .period_evt(period_evt), .cmp_evt(cmp_evt),
        .period(period), .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en),
        .count_reset(count_reset), .prescale(prescale), .compare1(compare1),
        .compare2(compare2), .functions(functions), .irq(irq)
    );

    pwm_regbank_mc #(.NUM_CH(2), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read_8), .rd_valid(rd_valid_8),
        .counter_val(counter_val[7:0]), .period_evt(period_evt), .cmp_evt(cmp_evt),
        .period(period_8), .en(en_8), .upnotdown(upnotdown_8), .pwm_en(pwm_en_8),
        .count_reset(count_reset_8), .prescale(prescale_8), .compare1(compare1_8),
        .compare2(compare2_8), .functions(functions_8), .irq(irq_8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1;
        addr = a;
        data_write = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        @(negedge clk);
        read = 1'b1;
        addr = a;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_period", period, 16'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_data_read", data_read, 8'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_count_reset", count_reset, 1'b0);
        chk("rst_compare1", compare1, 32'h0);
        chk("rst_period_8", period_8, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(6'h00, 8'h34);
        chk("period_lo_direct", period, 16'h0034);
        chk("period_lo_direct_8", period_8, 8'h34);
        wr(6'h01, 8'h12);
        chk("period_hi_direct", period, 16'h1234);
        chk("period_hi_ignored_8", period_8, 8'h34);
        rd(6'h01);
        chk("rd_period_hi", data_read, 8'h12);
        chk("rd_valid_hi", rd_valid, 1'b1);
        chk("rd_period_hi_8", data_read_8, 8'h00);
        @(negedge clk);
        chk("rd_valid_idle", rd_valid, 1'b0);
        chk("rd_data_idle", data_read, 8'h00);

        wr(6'h02, 8'h0F);
        chk("ctrl_outputs", {en, upnotdown, pwm_en}, 3'b111);
        rd(6'h02);
        chk("rd_ctrl", data_read, 8'h0F);

        wr(6'h18, 8'hC8);
        wr(6'h19, 8'h00);
        chk("cmp1_ch1_held", compare1[31:16], 16'h0000);
        rd(6'h18);
        chk("rd_cmp1_ch1_shadow", data_read, 8'hC8);
        @(negedge clk);
        period_evt = 1'b1;
        @(negedge clk);
        period_evt = 1'b0;
        chk("cmp1_ch1_commit", compare1[31:16], 16'h00C8);
        @(negedge clk);
        write = 1'b1;
        addr = 6'h18;
        data_write = 8'h64;
        period_evt = 1'b1;
        @(negedge clk);
        write = 1'b0;
        period_evt = 1'b0;
        chk("cmp1_ch1_collide", compare1[31:16], 16'h00C8);
        @(negedge clk);
        period_evt = 1'b1;
        @(negedge clk);
        period_evt = 1'b0;
        chk("cmp1_ch1_next_evt", compare1[31:16], 16'h0064);
        chk("cmp1_8", compare1_8, 16'h6400);

        wr(6'h00, 8'h99);
        chk("period_shadow_held", period, 16'h1234);
        wr(6'h09, 8'h01);
        chk("period_force", period, 16'h1299);
        chk("period_force_8", period_8, 8'h99);

        wr(6'h08, 8'h01);
        @(negedge clk);
        cmp_evt = 2'b01;
        @(negedge clk);
        cmp_evt = 2'b00;
        chk("irq_lags_status", irq, 1'b0);
        rd(6'h07);
        chk("rd_status_set", data_read, 8'h01);
        chk("irq_set", irq, 1'b1);
        @(negedge clk);
        write = 1'b1;
        addr = 6'h07;
        data_write = 8'h01;
        cmp_evt = 2'b01;
        @(negedge clk);
        write = 1'b0;
        cmp_evt = 2'b00;
        rd(6'h07);
        chk("status_set_wins", data_read, 8'h01);
        chk("irq_set_wins", irq, 1'b1);
        wr(6'h07, 8'h01);
        chk("irq_clear_lag", irq, 1'b1);
        @(negedge clk);
        chk("irq_cleared", irq, 1'b0);
        @(negedge clk);
        cmp_evt = 2'b10;
        @(negedge clk);
        cmp_evt = 2'b00;
        rd(6'h07);
        chk("rd_status_ch1", data_read, 8'h02);
        chk("irq_masked", irq, 1'b0);
        wr(6'h07, 8'h02);

        wr(6'h04, 8'h01);
        chk("count_reset_pulse", count_reset, 1'b1);
        @(negedge clk);
        chk("count_reset_drop", count_reset, 1'b0);
        rd(6'h04);
        chk("rd_counter_reset", data_read, 8'h00);

        counter_val = 16'hBEEF;
        rd(6'h05);
        chk("rd_cnt_lo", data_read, 8'hEF);
        rd(6'h06);
        chk("rd_cnt_hi", data_read, 8'hBE);
        chk("rd_cnt_hi_8", data_read_8, 8'h00);

        @(negedge clk);
        read = 1'b1;
        write = 1'b1;
        addr = 6'h03;
        data_write = 8'h55;
        @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        chk("rd_wr_same_old", data_read, 8'h00);
        chk("prescale_written", prescale, 8'h55);
        rd(6'h03);
        chk("rd_prescale", data_read, 8'h55);

        wr(6'h20, 8'hAA);
        chk("bad_ch_cmp1", compare1, 32'h0064_0000);
        chk("bad_ch_cmp2", compare2, 32'h0);
        rd(6'h20);
        chk("rd_bad_ch", data_read, 8'h00);
        rd(6'h0A);
        chk("rd_unmapped", data_read, 8'h00);
        wr(6'h14, 8'h03);
        wr(6'h01, 8'h77);
        chk("func_shadow_held", functions, 4'h0);
        chk("period_hi_held", period, 16'h1299);
        rd(6'h14);
        chk("rd_func_shadow", data_read, 8'h03);
        rd(6'h15);
        chk("rd_reserved", data_read, 8'h00);
        rd(6'h01);
        chk("rd_period_hi_8b", data_read_8, 8'h00);
        wr(6'h09, 8'h01);
        chk("func_force", functions, 4'h3);
        chk("period_force_hi", period, 16'h7799);
        chk("period_force_hi_8", period_8, 8'h99);
        chk("func_force_8", functions_8, 4'h3);

        wr(6'h08, 8'h01);
        @(negedge clk);
        cmp_evt = 2'b01;
        @(negedge clk);
        cmp_evt = 2'b00;
        wr(6'h10, 8'h11);
        chk("irq_before_reset", irq, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_period", period, 16'h0);
        chk("async_rst_cmp1", compare1, 32'h0);
        chk("async_rst_func", functions, 4'h0);
        chk("async_rst_ctrl", {en, upnotdown, pwm_en}, 3'b000);
        chk("async_rst_prescale", prescale, 8'h0);
        chk("async_rst_irq", irq, 1'b0);
        chk("async_rst_period_8", period_8, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        period_evt = 1'b1;
        @(negedge clk);
        period_evt = 1'b0;
        chk("no_pending_commit", compare1, 32'h0);
        rd(6'h10);
        chk("rd_shadow_cleared", data_read, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_regbank_mc.md
PWM_REGBANK_MC -- requirements
Module: pwm_regbank_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of PWM compare channels (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 16, counter/compare width (legal 8 or 16).
REQ-003 SHALL have ports: clk  input  1  peripheral clock, single clock domain.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 read  input  1  read strobe; write  input  1  write strobe; addr  input  6  byte address; data_write  input  8  write data.
REQ-006 data_read  output  8  registered read data; rd_valid  output  1  read-data qualifier.
REQ-007 counter_val  input  CNT_W  live counter value; period_evt  input  1  one-cycle pulse at counter period boundary; cmp_evt  input  NUM_CH  one-cycle compare-match pulses.
REQ-008 period  output  CNT_W; en, upnotdown, pwm_en, count_reset  output  1 each; prescale  output  8.
REQ-009 compare1, compare2  output  CNT_W*NUM_CH each, channel ch at [ch*CNT_W +: CNT_W]; functions  output  2*NUM_CH; irq  output  1.

Function
REQ-010 Global map SHALL be: 0x00/0x01 PERIOD L/H; 0x02 CTRL {bit0 en, bit1 upnotdown, bit2 pwm_en, bit3 shadow_en}; 0x03 PRESCALE; 0x04 COUNTER_RESET (WO); 0x05/0x06 COUNTER_VAL L/H (RO); 0x07 STATUS (W1C, bits NUM_CH-1:0); 0x08 IRQ_MASK; 0x09 FORCE_UPDATE (WO).
REQ-011 Channel ch SHALL occupy 0x10+8*ch: +0/+1 CMP1 L/H, +2/+3 CMP2 L/H, +4 FUNCTIONS[1:0]; +5..+7 reserved.
REQ-012 Addresses outside REQ-010/011, channels >= NUM_CH, and high bytes when CNT_W=8 SHALL ignore writes and read 0x00.
REQ-013 PERIOD, CMP1, CMP2, FUNCTIONS SHALL be double-buffered: writes update shadow; outputs drive active copy.
REQ-014 With shadow_en=0, active SHALL update on the same clock edge as the shadow write.
REQ-015 With shadow_en=1, all active copies SHALL load from shadow on the edge where period_evt=1 or a write of bit0=1 to FORCE_UPDATE occurs.
REQ-016 Shadow write coinciding with a commit SHALL commit the pre-write shadow value; new value waits for next commit.
REQ-017 CTRL, PRESCALE, IRQ_MASK SHALL be unbuffered, updating on write edge.
REQ-018 Writing bit0=1 to COUNTER_RESET SHALL assert count_reset for exactly one cycle following the write edge; otherwise 0.
REQ-019 STATUS[ch] SHALL set on cmp_evt[ch]=1 and clear on write with data_write[ch]=1; simultaneous set and clear SHALL leave it set.
REQ-020 irq SHALL be registered: irq = |(STATUS & IRQ_MASK[NUM_CH-1:0]), one cycle after state change.
REQ-021 Read SHALL have latency 1: data_read and rd_valid valid the cycle after read=1; rd_valid=0 and data_read=0x00 otherwise.
REQ-022 Reads of buffered registers SHALL return shadow; WO registers read 0x00; unused bits read 0.
REQ-023 Read and write to the same address in one cycle SHALL return the pre-write value.
REQ-024 COUNTER_VAL read SHALL sample counter_val at the read cycle.

Reset
REQ-025 On rst_n low, all shadow, active, CTRL, PRESCALE, STATUS, IRQ_MASK, count_reset, irq, data_read, rd_valid SHALL clear to 0 immediately, regardless of clk.
REQ-026 Reset mid-transaction SHALL abort it; no pending commit survives reset.

Structure
REQ-027 Package pwm_regbank_pkg SHALL hold address constants, channel base/stride (0x10/8), CTRL bit indices.
REQ-028 Per-channel shadow/active/status logic SHALL be sub-module pwm_ch_regs, instantiated NUM_CH times via generate.

Verification
REQ-029 shadow_en=0, write 0x00=0x34, 0x01=0x12 -> period=0x1234 on each write edge; read 0x01 -> data_read=0x12, rd_valid=1 one cycle later.
REQ-030 shadow_en=1, write ch1 CMP1=0x00C8 -> compare1 ch1 unchanged until period_evt pulse, then 0x00C8 next cycle; write at same edge as period_evt -> held to next event.
REQ-031 IRQ_MASK=0x01, cmp_evt[0] pulse -> STATUS=0x01, irq=1; write STATUS=0x01 concurrent with cmp_evt[0] -> stays 0x01; clear alone -> irq=0 next cycle.
REQ-032 Write 0x04=0x01 -> count_reset high exactly one cycle; read 0x04 -> 0x00.
REQ-033 NUM_CH=2, CNT_W=8: write 0x20 and 0x01 -> no output change, reads 0x00; FORCE_UPDATE commits all shadows.
REQ-034 Assert rst_n low between two clk edges after programming -> all outputs 0 immediately.
